// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - two-master data RAM arbiter/sequencer with watchdog; optional ARB_ROUND_ROBIN_EN
module data_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_sel,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [3:0]  dma_sel,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        timeout_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_BUSY_CPU = 3'd1;
  localparam logic [2:0] S_BUSY_DMA = 3'd2;
  localparam logic [2:0] S_DONE_CPU = 3'd3;
  localparam logic [2:0] S_DONE_DMA = 3'd4;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic       grant_cpu;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = CPU won the previous grant, 0 = DMA (reset value)
  logic last_grant;

  // Under contention the requester not granted last time wins
  always_comb begin
    grant_cpu = cpu_ce && (!dma_req || !last_grant);
  end
`else
  // Fixed priority: the CPU wins whenever it requests
  always_comb begin
    grant_cpu = cpu_ce;
  end
`endif

  // The pipeline is held for the whole access except the CPU's completion cycle
  assign cpu_stall = cpu_ce && (state != S_DONE_CPU);

  // Transaction sequencer: latch the winner, wait for ack or watchdog, report completion
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      ram_ce      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= 32'd0;
      ram_sel     <= 4'd0;
      ram_wdata   <= 32'd0;
      cpu_rdata   <= 32'd0;
      dma_rdata   <= 32'd0;
      dma_ack     <= 1'b0;
      timeout_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant  <= 1'b0;
`endif
    end else begin
      dma_ack     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= 8'd0;
          if (grant_cpu) begin
            ram_ce    <= 1'b1;
            ram_we    <= cpu_we;
            ram_addr  <= cpu_addr;
            ram_sel   <= cpu_sel;
            ram_wdata <= cpu_wdata;
            state     <= S_BUSY_CPU;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
          end else if (dma_req) begin
            ram_ce    <= 1'b1;
            ram_we    <= dma_we;
            ram_addr  <= dma_addr;
            ram_sel   <= dma_sel;
            ram_wdata <= dma_wdata;
            state     <= S_BUSY_DMA;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
          end
        end
        S_BUSY_CPU, S_BUSY_DMA: begin
          // An ack on the last watchdog cycle still completes normally
          if (ram_ack) begin
            if (state == S_BUSY_CPU) cpu_rdata <= ram_rdata;
            else                     dma_rdata <= ram_rdata;
            ram_ce  <= 1'b0;
            ram_we  <= 1'b0;
            dma_ack <= (state == S_BUSY_DMA);
            state   <= (state == S_BUSY_CPU) ? S_DONE_CPU : S_DONE_DMA;
          end else if (cnt == LAST_CNT) begin
            if (state == S_BUSY_CPU) cpu_rdata <= 32'd0;
            else                     dma_rdata <= 32'd0;
            ram_ce      <= 1'b0;
            ram_we      <= 1'b0;
            timeout_err <= 1'b1;
            dma_ack     <= (state == S_BUSY_DMA);
            state       <= (state == S_BUSY_CPU) ? S_DONE_CPU : S_DONE_DMA;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE_CPU, S_DONE_DMA: begin
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          ram_ce <= 1'b0;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - randomized self-checking bench for data_bus_arbiter
module tb_data_bus_arbiter;

  localparam int TO = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [3:0]  cpu_sel, dma_sel;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        cpu_stall, dma_ack;
  logic        ram_ce, ram_we, ram_ack, timeout_err;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  int errors = 0;
  int checks = 0;
  bit last_cpu = 1'b0;

  data_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_sel(cpu_sel),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_sel(dma_sel),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // One complete access from the IDLE sampling cycle to the following IDLE cycle.
  // ack_at = BUSY cycle on which the RAM acks (0 = never).
  task automatic run_txn(input bit c_req, input bit d_req, input int ack_at,
                         input logic [31:0] rd_val, input string tag);
    bit          win_cpu, exp_err;
    int          exp_done;
    logic [31:0] exp_data, e_addr, e_wdata;
    logic [3:0]  e_sel;
    logic        e_we;
    @(negedge clk);
    cpu_ce  = c_req;
    dma_req = d_req;
    ram_ack = 1'b0;
    win_cpu = RR ? (c_req && (!d_req || !last_cpu)) : c_req;
    last_cpu = win_cpu;
    e_we    = win_cpu ? cpu_we    : dma_we;
    e_addr  = win_cpu ? cpu_addr  : dma_addr;
    e_sel   = win_cpu ? cpu_sel   : dma_sel;
    e_wdata = win_cpu ? cpu_wdata : dma_wdata;
    exp_err  = !(ack_at >= 1 && ack_at <= TO);
    exp_done = exp_err ? TO + 1 : ack_at + 1;
    exp_data = exp_err ? 32'd0 : rd_val;
    #1;
    checks++;
    if (cpu_stall !== c_req) begin
      errors++; $display("FAIL %s idle_stall got=%b want=%b", tag, cpu_stall, c_req);
    end
    for (int c = 1; c < exp_done; c++) begin
      @(negedge clk);
      checks++;
      if ({ram_ce, ram_we, ram_addr, ram_sel, ram_wdata} !== {1'b1, e_we, e_addr, e_sel, e_wdata}) begin
        errors++;
        $display("FAIL %s busy_ram c=%0d got ce=%b we=%b a=%h s=%h d=%h want ce=1 we=%b a=%h s=%h d=%h",
                 tag, c, ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, e_we, e_addr, e_sel, e_wdata);
      end
      checks++;
      if ({cpu_stall, dma_ack, timeout_err} !== {c_req, 2'b00}) begin
        errors++; $display("FAIL %s busy_flags c=%0d got=%b want=%b", tag, c,
                           {cpu_stall, dma_ack, timeout_err}, {c_req, 2'b00});
      end
      // Requester fields may change once latched
      cpu_addr  = $urandom; cpu_wdata = $urandom;
      dma_addr  = $urandom; dma_wdata = $urandom;
      ram_ack   = (c == ack_at);
      ram_rdata = (c == ack_at) ? rd_val : $urandom;
    end
    @(negedge clk);
    ram_ack = 1'b0;
    checks++;
    if ({ram_ce, ram_we, timeout_err} !== {2'b00, exp_err}) begin
      errors++; $display("FAIL %s done_ce_err got ce=%b we=%b err=%b want ce=0 we=0 err=%b",
                         tag, ram_ce, ram_we, timeout_err, exp_err);
    end
    checks++;
    if (win_cpu) begin
      if ({cpu_stall, dma_ack, cpu_rdata} !== {2'b00, exp_data}) begin
        errors++; $display("FAIL %s done_cpu got stall=%b ack=%b rd=%h want stall=0 ack=0 rd=%h",
                           tag, cpu_stall, dma_ack, cpu_rdata, exp_data);
      end
    end else begin
      if ({cpu_stall, dma_ack, dma_rdata} !== {c_req, 1'b1, exp_data}) begin
        errors++; $display("FAIL %s done_dma got stall=%b ack=%b rd=%h want stall=%b ack=1 rd=%h",
                           tag, cpu_stall, dma_ack, dma_rdata, c_req, exp_data);
      end
    end
    cpu_ce  = 1'b0;
    dma_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_ce, dma_ack, timeout_err, cpu_stall} !== 4'b0000) begin
      errors++; $display("FAIL %s after_done got=%b want=0000", tag,
                         {ram_ce, dma_ack, timeout_err, cpu_stall});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_ce = 1'b1; dma_req = 1'b1; ram_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, cpu_rdata, dma_rdata, dma_ack, timeout_err} !== '0) begin
      errors++; $display("FAIL reset_outputs got ce=%b we=%b a=%h s=%h d=%h crd=%h drd=%h ack=%b err=%b want all 0",
                         ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, cpu_rdata, dma_rdata, dma_ack, timeout_err);
    end
    checks++;
    if (cpu_stall !== 1'b1) begin
      errors++; $display("FAIL reset_stall got=%b want=1", cpu_stall);
    end
    cpu_ce = 1'b0; dma_req = 1'b0; ram_ack = 1'b0;
    rst = 1'b1;
    last_cpu = 1'b0;
  endtask

  task automatic test_cpu_read();
    cpu_we = 1'b0; cpu_addr = 32'h0000_1234; cpu_sel = 4'hF; cpu_wdata = $urandom;
    run_txn(1'b1, 1'b0, 1, 32'h1234_5678, "cpu_read");
  endtask

  task automatic test_dma_write();
    dma_we = 1'b1; dma_addr = 32'h40; dma_sel = 4'b0011; dma_wdata = $urandom;
    run_txn(1'b0, 1'b1, 3, $urandom, "dma_write");
  endtask

  task automatic test_timeout();
    cpu_we = 1'b0; cpu_addr = $urandom; cpu_sel = 4'hF;
    run_txn(1'b1, 1'b0, 0, $urandom, "cpu_timeout");
    dma_we = 1'b0; dma_addr = $urandom; dma_sel = 4'h3;
    run_txn(1'b0, 1'b1, 0, $urandom, "dma_timeout");
  endtask

  task automatic test_ack_last_cycle();
    cpu_we = 1'b1; cpu_addr = $urandom; cpu_sel = 4'h5; cpu_wdata = $urandom;
    run_txn(1'b1, 1'b0, TO, 32'hCAFE_F00D, "ack_last");
  endtask

  task automatic test_arbitration();
    for (int r = 0; r < 4; r++) begin
      cpu_we = $urandom; cpu_addr = $urandom; cpu_sel = $urandom; cpu_wdata = $urandom;
      dma_we = $urandom; dma_addr = $urandom; dma_sel = $urandom; dma_wdata = $urandom;
      run_txn(1'b1, 1'b1, 1 + (r % 2), $urandom, "contend");
    end
  endtask

  task automatic test_reset_mid_dma();
    dma_we = 1'b1; dma_addr = 32'h80; dma_sel = 4'hF; dma_wdata = $urandom;
    @(negedge clk);
    dma_req = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, cpu_rdata, dma_rdata, dma_ack, timeout_err} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got ce=%b a=%h ack=%b err=%b want all 0",
                         ram_ce, ram_addr, dma_ack, timeout_err);
    end
    rst = 1'b1; ram_ack = 1'b1;
    last_cpu = 1'b0;
    for (int c = 0; c < TO + 3; c++) begin
      @(negedge clk);
      checks++;
      if ({ram_ce, dma_ack, timeout_err} !== 3'b000) begin
        errors++; $display("FAIL mid_reset_quiet c=%0d got=%b want=000", c, {ram_ce, dma_ack, timeout_err});
      end
    end
    ram_ack = 1'b0;
  endtask

  task automatic test_random();
    bit c, d;
    for (int r = 0; r < 24; r++) begin
      c = $urandom; d = $urandom;
      if (!c && !d) c = 1'b1;
      cpu_we = $urandom; cpu_addr = $urandom; cpu_sel = $urandom; cpu_wdata = $urandom;
      dma_we = $urandom; dma_addr = $urandom; dma_sel = $urandom; dma_wdata = $urandom;
      run_txn(c, d, $urandom_range(0, TO), $urandom, "random");
    end
  endtask

  initial begin
    rst = 1'b0; cpu_ce = 1'b0; dma_req = 1'b0; ram_ack = 1'b0; ram_rdata = '0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_sel = '0; cpu_wdata = '0;
    dma_we = 1'b0; dma_addr = '0; dma_sel = '0; dma_wdata = '0;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_timeout();
    test_ack_last_cycle();
    test_arbitration();
    test_reset_mid_dma();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
